// File: rtl/rgy_pkg.sv
// rgy_pkg: lamp indices, monitor states and fault codes shared by the rgy conflict monitor.
package rgy_pkg;
  localparam int RED = 0, YELLOW = 1, GREEN = 2;
  localparam logic [2:0] L_R = 3'(1 << RED), L_Y = 3'(1 << YELLOW), L_G = 3'(1 << GREEN);
  typedef enum logic [1:0] {ST_INIT, ST_MONITOR, ST_FAULT} state_e;
  localparam logic [2:0] FC_NONE = 3'd0, FC_MULTI = 3'd1, FC_CONFLICT = 3'd2,
                         FC_SEQ = 3'd3, FC_SHORT = 3'd4, FC_DARK = 3'd5;
endpackage

// File: rtl/rgy_channel_check.sv
// rgy_channel_check: per-channel lamp sequence, yellow-length and dark-head supervision.
module rgy_channel_check
  import rgy_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DARK   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [2:0] rgy_i,
  output logic       multi_o,
  output logic       seq_o,
  output logic       short_o,
  output logic       dark_o,
  output logic       perm_o
);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int DW = $clog2(MAX_DARK + 1);
  logic [2:0] last_q, last_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic lit, legal;
  always_comb begin
    lit = |rgy_i;
    legal = rgy_i == last_q || (last_q == L_R && rgy_i == L_G) ||
            (last_q == L_G && rgy_i == L_Y) || (last_q == L_Y && rgy_i == L_R);
    multi_o = (rgy_i[RED] & rgy_i[YELLOW]) | (rgy_i[RED] & rgy_i[GREEN]) | (rgy_i[YELLOW] & rgy_i[GREEN]);
    seq_o = lit && !legal;
    short_o = last_q == L_Y && rgy_i == L_R && ycnt_q < YW'(MIN_YELLOW);
    dark_o = !lit && dcnt_q == DW'(MAX_DARK);
    perm_o = rgy_i[YELLOW] | rgy_i[GREEN];
    // Outside MONITOR everything rearms to "last lamp red, no runs in progress".
    last_d = !en_i ? L_R : lit ? rgy_i : last_q;
    ycnt_d = !en_i ? '0 : !lit ? ycnt_q : rgy_i != L_Y ? '0 :
             ycnt_q == YW'(MIN_YELLOW) ? ycnt_q : ycnt_q + 1'b1;
    dcnt_d = (!en_i || lit) ? '0 : dcnt_q == DW'(MAX_DARK) ? dcnt_q : dcnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= L_R;
      ycnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      last_q <= last_d;
      ycnt_q <= ycnt_d;
      dcnt_q <= dcnt_d;
    end
  end
endmodule

// File: rtl/rgy_conflict_monitor.sv
// rgy_conflict_monitor: supervises two rgy lamp channels, latches the first fault and
// forces both heads to flashing red until cleared.
module rgy_conflict_monitor
  import rgy_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DARK   = 3,
  parameter int FLASH_DIV  = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rgy0,
  input  logic [3:0]       rgy1,
  input  logic             clear,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [3:0]       lamp0,
  output logic [3:0]       lamp1
);
  localparam int FW = $clog2(2 * FLASH_DIV);
  state_e state_q, state_d;
  logic [2:0] code_q, code_d, code, l0_q, l0_d, l1_q, l1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fc_q, fc_d;
  logic multi0, seq0, short0, dark0, perm0, multi1, seq1, short1, dark1, perm1;
  logic unused_bit3;
  assign unused_bit3 = rgy0[3] ^ rgy1[3];
  rgy_channel_check #(.MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK)) u_ch0 (
    .clk(clk), .reset(reset), .en_i(state_q == ST_MONITOR), .rgy_i(rgy0[2:0]),
    .multi_o(multi0), .seq_o(seq0), .short_o(short0), .dark_o(dark0), .perm_o(perm0));
  rgy_channel_check #(.MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK)) u_ch1 (
    .clk(clk), .reset(reset), .en_i(state_q == ST_MONITOR), .rgy_i(rgy1[2:0]),
    .multi_o(multi1), .seq_o(seq1), .short_o(short1), .dark_o(dark1), .perm_o(perm1));
  always_comb begin
    code = (multi0 | multi1) ? FC_MULTI : (perm0 & perm1) ? FC_CONFLICT :
           (seq0 | seq1) ? FC_SEQ : (short0 | short1) ? FC_SHORT :
           (dark0 | dark1) ? FC_DARK : FC_NONE;
    state_d = state_q;
    code_d = code_q;
    cnt_d = cnt_q;
    fc_d = '0;
    l0_d = L_R;
    l1_d = L_R;
    if (state_q == ST_INIT) begin
      state_d = (rgy0[2:0] == L_R && rgy1[2:0] == L_R) ? ST_MONITOR : ST_INIT;
    end else if (state_q == ST_MONITOR) begin
      if (code != FC_NONE) begin
        state_d = ST_FAULT;
        code_d = code;
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      end else begin
        l0_d = rgy0[2:0];
        l1_d = rgy1[2:0];
      end
    end else if (clear) begin
      state_d = ST_INIT;
      code_d = FC_NONE;
    end else begin
      // Flash phase counter: first FLASH_DIV cycles red, next FLASH_DIV dark.
      fc_d = fc_q == FW'(2 * FLASH_DIV - 1) ? '0 : fc_q + 1'b1;
      l0_d = fc_d < FW'(FLASH_DIV) ? L_R : 3'b000;
      l1_d = l0_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      code_q <= FC_NONE;
      cnt_q <= '0;
      fc_q <= '0;
      l0_q <= L_R;
      l1_q <= L_R;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
      fc_q <= fc_d;
      l0_q <= l0_d;
      l1_q <= l1_d;
    end
  end
  assign fault = state_q == ST_FAULT;
  assign fault_code = code_q;
  assign fault_cnt = cnt_q;
  assign lamp0 = {1'b0, l0_q};
  assign lamp1 = {1'b0, l1_q};
endmodule

// File: tb/tb_rgy_conflict_monitor.sv
// tb_rgy_conflict_monitor: directed scenarios checked against a history-based behavioural model.
module tb_rgy_conflict_monitor;
  localparam int MIN_YELLOW = 2, MAX_DARK = 3, FLASH_DIV = 4, CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [3:0] R = 4'b0001, Y = 4'b0010, G = 4'b0100, OFF = 4'b0000;
  logic clk = 0, reset = 1, clear = 0;
  logic [3:0] rgy0 = R, rgy1 = R;
  logic fault;
  logic [2:0] fault_code;
  logic [CNT_W-1:0] fault_cnt;
  logic [3:0] lamp0, lamp1;
  int errors = 0, checks = 0;

  rgy_conflict_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK), .FLASH_DIV(FLASH_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rgy0(rgy0), .rgy1(rgy1), .clear(clear),
    .fault(fault), .fault_code(fault_code), .fault_cnt(fault_cnt), .lamp0(lamp0), .lamp1(lamp1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: 0 init, 1 monitor, 2 fault; per-channel lamp history since entering monitor.
  int m_state = 0, m_code = 0, m_cnt = 0, m_fc = 0, m_v = 0;
  logic [3:0] m_l0 = R, m_l1 = R;
  logic [2:0] h0[$], h1[$];

  function automatic int chan_viol(input int ch, input logic [2:0] cur);
    logic [2:0] h[$];
    logic [2:0] last;
    int yrun, drun, v;
    if (ch == 1) h = h1; else h = h0;
    last = 3'b001; yrun = 0; drun = 0; v = 0;
    foreach (h[i]) if (h[i] != 0) last = h[i];
    for (int i = h.size() - 1; i >= 0; i--) begin
      if (h[i] != 0) break;
      drun++;
    end
    for (int i = h.size() - 1; i >= 0; i--) begin
      if (h[i] == 0) continue;
      if (h[i] == 3'b010) yrun++; else break;
    end
    if ($countones(cur) > 1) v |= 2;
    if (cur != 0 && !(cur == last || (last == 3'b001 && cur == 3'b100) ||
        (last == 3'b100 && cur == 3'b010) || (last == 3'b010 && cur == 3'b001))) v |= 8;
    if (last == 3'b010 && cur == 3'b001 && yrun < MIN_YELLOW) v |= 16;
    if (cur == 0 && drun >= MAX_DARK) v |= 32;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_code = 0; m_cnt = 0; m_fc = 0; m_l0 = R; m_l1 = R;
    end else if (m_state == 0) begin
      m_l0 = R; m_l1 = R;
      if (rgy0[2:0] == 3'b001 && rgy1[2:0] == 3'b001) begin
        m_state = 1; h0.delete(); h1.delete();
      end
    end else if (m_state == 1) begin
      m_v = chan_viol(0, rgy0[2:0]) | chan_viol(1, rgy1[2:0]);
      if ((rgy0[1] | rgy0[2]) && (rgy1[1] | rgy1[2])) m_v |= 4;
      if (m_v != 0) begin
        m_state = 2; m_fc = 0; m_l0 = R; m_l1 = R;
        for (int i = 5; i >= 1; i--) if (m_v[i]) m_code = i;
        m_cnt = m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX;
      end else begin
        h0.push_back(rgy0[2:0]); h1.push_back(rgy1[2:0]);
        if (h0.size() > 32) begin void'(h0.pop_front()); void'(h1.pop_front()); end
        m_l0 = {1'b0, rgy0[2:0]}; m_l1 = {1'b0, rgy1[2:0]};
      end
    end else if (clear) begin
      m_state = 0; m_code = 0; m_l0 = R; m_l1 = R;
    end else begin
      m_fc++;
      m_l0 = ((m_fc / FLASH_DIV) % 2 == 0) ? R : OFF;
      m_l1 = m_l0;
    end
  end

  always @(negedge clk) begin
    chk("fault", int'(fault), int'(m_state == 2));
    chk("fault_code", int'(fault_code), m_code);
    chk("fault_cnt", int'(fault_cnt), m_cnt);
    chk("lamp0", int'(lamp0), int'(m_l0));
    chk("lamp1", int'(lamp1), int'(m_l1));
  end

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    rgy0 = a; rgy1 = b; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_code"}, int'(fault_code), 0);
    chk({tag, "_cnt"}, int'(fault_cnt), 0);
    chk({tag, "_lamp0"}, int'(lamp0), 1);
    chk({tag, "_lamp1"}, int'(lamp1), 1);
  endtask

  initial begin
    #2 reset = 0;
    #20;
    rst_vals("reset");
    @(negedge clk) reset = 1;
    step(R, R, 0);
    chk("t1_lamp0_r", int'(lamp0), 1);
    step(G, R, 0);
    chk("t1_lamp0_g", int'(lamp0), 4);
    repeat (3) step(Y, R, 0);
    chk("t1_lamp0_y", int'(lamp0), 2);
    step(4'b1001, 4'b1001, 0);
    chk("t1_no_fault", int'(fault), 0);
    chk("t1_lamp0_bit3", int'(lamp0), 1);
    chk("t1_lamp1_bit3", int'(lamp1), 1);
    step(G, G, 0);
    chk("t2_fault", int'(fault), 1);
    chk("t2_code", int'(fault_code), 2);
    chk("t2_cnt", int'(fault_cnt), 1);
    chk("t2_flash0", int'(lamp0), 1);
    repeat (3) step(R, R, 0);
    chk("t2_flash3", int'(lamp0), 1);
    step(G, R, 0);
    chk("t2_flash4", int'(lamp1), 0);
    chk("t2_code_frozen", int'(fault_code), 2);
    repeat (4) step(R, R, 0);
    chk("t2_flash8", int'(lamp0), 1);
    step(R, R, 1);
    chk("t2_clr_fault", int'(fault), 0);
    chk("t2_clr_code", int'(fault_code), 0);
    chk("t2_clr_cnt", int'(fault_cnt), 1);
    chk("t2_clr_lamp0", int'(lamp0), 1);
    step(R, R, 0);
    step(G, R, 0);
    step(R, R, 0);
    chk("t3_code", int'(fault_code), 3);
    chk("t3_cnt", int'(fault_cnt), 2);
    step(R, R, 1);
    step(R, R, 0);
    step(R, G, 0);
    step(R, Y, 0);
    step(R, R, 0);
    chk("t4_code", int'(fault_code), 4);
    chk("t4_cnt", int'(fault_cnt), 3);
    step(R, R, 1);
    step(R, R, 0);
    repeat (3) step(OFF, R, 0);
    step(R, R, 0);
    chk("t5_dark3_ok", int'(fault), 0);
    repeat (3) step(OFF, R, 0);
    chk("t5_dark3_again", int'(fault), 0);
    step(OFF, R, 0);
    chk("t5_code", int'(fault_code), 5);
    chk("t5_cnt", int'(fault_cnt), 4);
    step(R, R, 1);
    step(R, R, 0);
    step(4'b0101, G, 0);
    chk("t6_code", int'(fault_code), 1);
    chk("t6_cnt", int'(fault_cnt), 5);
    step(R, R, 1);
    repeat (252) begin
      step(R, R, 0);
      step(G, G, 0);
      step(R, R, 1);
    end
    chk("t6_sat", int'(fault_cnt), 255);
    step(R, R, 0);
    step(G, G, 0);
    chk("t6_sat_fault", int'(fault), 1);
    chk("t6_sat_hold", int'(fault_cnt), 255);
    @(negedge clk);
    #2 reset = 0;
    #1;
    rst_vals("midrst");
    repeat (2) @(negedge clk);
    #2 reset = 1;
    step(R, R, 0);
    step(G, R, 0);
    chk("post_lamp0", int'(lamp0), 4);
    chk("post_fault", int'(fault), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
